// File: rtl/mult_booth_r8_seq_pkg.sv
// mult_pkg: shared FSM encoding, Booth digit select type and iteration-count helper.
package mult_pkg;
    typedef logic [1:0] mult_state_t;
    localparam mult_state_t IDLE = 2'd0;
    localparam mult_state_t CALC = 2'd1;
    localparam mult_state_t DONE = 2'd2;
    // sel is one-hot {4M,3M,2M,1M}; all-zero sel is the zero digit, which never carries neg
    typedef struct packed {
        logic       neg;
        logic [3:0] sel;
    } booth_sel_t;
    function automatic int booth_iter(input int width);
        return (width + 4) / 3;
    endfunction
endpackage

// File: rtl/mult_booth_r8_seq_if.sv
// mult_booth_r8_seq_if: operand request and product response handshakes of the radix-8 multiplier.
interface mult_booth_r8_seq_if #(parameter int WIDTH = 16);
    logic               req_valid;
    logic               req_ready;
    logic               signed_mode;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   q;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*WIDTH-1:0] z;
    logic               busy;
    modport master (output req_valid, signed_mode, m, q, rsp_ready, input req_ready, rsp_valid, z, busy);
    modport slave (input req_valid, signed_mode, m, q, rsp_ready, output req_ready, rsp_valid, z, busy);
endinterface

// File: rtl/mult_booth_r8_seq_recoder.sv
// booth_r8_recoder: maps a 4-bit overlapping multiplier group to a radix-8 Booth digit select.
module booth_r8_recoder
    import mult_pkg::*;
(
    input  logic [3:0] grp,
    output booth_sel_t sel
);
    logic [3:0] v;
    logic [3:0] mag;
    // digit = -4*g3 + 2*g2 + g1 + g0, computed mod 16 so v[3] is the sign
    always_comb begin
        v = {2'b00, grp[2], 1'b0} + {3'b000, grp[1]} + {3'b000, grp[0]} - {1'b0, grp[3], 2'b00};
        mag = v[3] ? -v : v;
        sel.neg = v[3];
        sel.sel = {mag == 4'd4, mag == 4'd3, mag == 4'd2, mag == 4'd1};
    end
endmodule

// File: rtl/mult_booth_r8_seq.sv
// mult_booth_r8_seq: sequential radix-8 Booth multiplier, one Booth digit accumulated per cycle.
module mult_booth_r8_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mult_booth_r8_seq_if.slave  bus
);
    localparam int ITER = booth_iter(WIDTH);
    localparam int MW   = WIDTH + 3;
    localparam int QW   = 3 * ITER;
    localparam int AW   = 2 * WIDTH;
    localparam int CW   = $clog2(ITER);
    localparam int SW   = CW + 2;
    mult_state_t   state;
    logic [CW-1:0] cnt;
    logic [MW-1:0] mx;
    logic [MW-1:0] m3;
    logic [QW-1:0] qx;
    logic          qprev;
    logic [AW-1:0] acc;
    logic          m_ext;
    logic          q_ext;
    logic [MW-1:0] mx_in;
    logic [MW-1:0] mag;
    logic [MW-1:0] pp;
    logic [AW-1:0] pp_ext;
    logic [SW-1:0] sh;
    booth_sel_t    sel;
    assign m_ext = bus.signed_mode & bus.m[WIDTH-1];
    assign q_ext = bus.signed_mode & bus.q[WIDTH-1];
    assign mx_in = {{3{m_ext}}, bus.m};
    // qx shifts right by one digit per cycle, so the current group always sits at the bottom
    booth_r8_recoder u_rec (
        .grp ({qx[2:0], qprev}),
        .sel (sel)
    );
    always_comb begin
        mag = sel.sel[0] ? mx :
              sel.sel[1] ? {mx[MW-2:0], 1'b0} :
              sel.sel[2] ? m3 :
              sel.sel[3] ? {mx[MW-3:0], 2'b00} : '0;
        pp = sel.neg ? ~mag + MW'(1) : mag;
        pp_ext = {{(AW-MW){pp[MW-1]}}, pp};
        sh = SW'(cnt) * SW'(3);
    end
    // accumulator kept at product width: bits above 2*WIDTH can never reach the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            mx    <= '0;
            m3    <= '0;
            qx    <= '0;
            qprev <= 1'b0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    state <= CALC;
                    mx    <= mx_in;
                    m3    <= mx_in + {mx_in[MW-2:0], 1'b0};
                    qx    <= {{(QW-WIDTH){q_ext}}, bus.q};
                    qprev <= 1'b0;
                    acc   <= '0;
                    cnt   <= '0;
                end
                CALC: begin
                    acc   <= acc + (pp_ext << sh);
                    qx    <= {3'b000, qx[QW-1:3]};
                    qprev <= qx[2];
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) state <= DONE;
                end
                DONE: if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.z         = acc;
endmodule

// File: tb/tb_mult_booth_r8_seq.sv
// tb_mult_booth_r8_seq: directed and small randomized checks of the 16-bit radix-8 Booth multiplier.
module tb_mult_booth_r8_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    mult_booth_r8_seq_if #(.WIDTH(16)) bus ();
    mult_booth_r8_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [31:0] exp, input int hold, input bit churn);
        int lat;
        @(negedge clk);
        bus.m = a;
        bus.q = b;
        bus.signed_mode = s;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            if (churn) begin
                bus.m = 16'($urandom);
                bus.q = 16'($urandom);
                bus.signed_mode = ~bus.signed_mode;
            end
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd6);
        chk({tag, "_z"}, 64'(bus.z), 64'(exp));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_bp_valid"}, 64'(bus.rsp_valid), 64'd1);
            chk({tag, "_bp_z"}, 64'(bus.z), 64'(exp));
            chk({tag, "_bp_ready"}, 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        chk({tag, "_post_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_post_ready"}, 64'(bus.req_ready), 64'd1);
    endtask
    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        longint      ra;
        longint      rb;
        int          seen;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.signed_mode = 1'b0;
        bus.m = '0;
        bus.q = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_z", 64'(bus.z), 64'd0);
        rst_n = 1'b1;
        do_op("u_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, 1'b0);
        do_op("s_8000_8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, 1'b0);
        do_op("s_ffff_0003", 16'hFFFF, 16'h0003, 1'b1, 32'hFFFFFFFD, 0, 1'b0);
        do_op("u_0003_0005", 16'h0003, 16'h0005, 1'b0, 32'h0000000F, 0, 1'b0);
        do_op("s_7fff_8000", 16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 0, 1'b0);
        do_op("u_8000_0002", 16'h8000, 16'h0002, 1'b0, 32'h00010000, 0, 1'b0);
        do_op("s_fffe_fffd", 16'hFFFE, 16'hFFFD, 1'b1, 32'h00000006, 0, 1'b0);
        do_op("u_00ff_0101", 16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, 0, 1'b0);
        do_op("s_0000_1234", 16'h0000, 16'h1234, 1'b1, 32'h00000000, 0, 1'b0);
        do_op("bp_s_0002_ffff", 16'h0002, 16'hFFFF, 1'b1, 32'hFFFFFFFE, 5, 1'b0);
        do_op("churn_u_1111_0003", 16'h1111, 16'h0003, 1'b0, 32'h00003333, 0, 1'b1);
        repeat (4) @(negedge clk);
        chk("idle_hold_z", 64'(bus.z), 64'h00003333);
        chk("idle_hold_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.m = 16'hAAAA;
        bus.q = 16'h5555;
        bus.signed_mode = 1'b0;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(bus.req_ready), 64'd1);
        chk("abort_valid", 64'(bus.rsp_valid), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_z", 64'(bus.z), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        do_op("u_1234_5678", 16'h1234, 16'h5678, 1'b0, 32'h06260060, 0, 1'b0);
        for (int n = 0; n < 200; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            ra = s ? longint'($signed(a)) : longint'(a);
            rb = s ? longint'($signed(b)) : longint'(b);
            do_op("rand", a, b, s, 32'(ra * rb), 0, 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
